cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Sequencer FSM for the 8-bit accumulator CPU. It drives the ALU, instruction register, program counter, accumulator and memory strobes. It consumes the opcode from the instruction register and the ALU `zero` flag.
- The design runs on an 8-phase instruction cycle. The ALU evaluates on negedge, so every controller output is stable before the ALU samples it.

Parameters:
- HALT_STICKY, 1, 1: HLT enters HALTED and stays there until reset. 0: `halt` pulses for one phase and sequencing continues.

Ports:
- clk, input, 1, system clock; phase advances on posedge.
- rst, input, 1, asynchronous active-high reset.
- opcode, input, 3, current instruction opcode (IR[7:5]).
- zero, input, 1, ALU flag, 1 when accumulator == 0.
- sel, output, 1, address mux select (1 = PC, 0 = IR operand).
- rd, output, 1, memory read enable.
- ld_ir, output, 1, load instruction register.
- inc_pc, output, 1, increment program counter.
- ld_pc, output, 1, load PC from IR operand (jump).
- ld_ac, output, 1, load accumulator from ALU out.
- wr, output, 1, memory write strobe.
- data_e, output, 1, enable ALU out onto data bus.
- halt, output, 1, halt indication.
- phase, output, 3, current phase (debug/verification).

Behaviour:
- Reset:
  - phase = INST_ADDR (0).
  - HALTED flag cleared.
  - All strobes are decoded from the reset state: sel = 1, everything else 0.
- Phase sequencing:
  - Order: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4) -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7) -> INST_ADDR.
  - Advance one phase per posedge. Wrap 7 -> 0.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. `aluop` = ADD|AND|XOR|LDA.
- Output decode: outputs are combinational from the registered phase, opcode and zero. No output registers.
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc, halt = (opcode==HLT).
  - OP_FETCH: rd = aluop.
  - ALU_OP: rd = aluop; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - STORE: rd = aluop; ld_ac = aluop; ld_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Halt:
  - With HALT_STICKY=1, the posedge that leaves OP_ADDR with opcode==HLT enters HALTED instead of OP_FETCH.
  - In HALTED: halt=1, phase output holds 4, all other strobes 0.
  - Only rst exits HALTED.
- `zero` and `opcode` are sampled only combinationally in the phases listed above. Changes in other phases have no effect.
- SKZ with zero=0: no extra inc_pc, so the next instruction executes normally.
- Reset mid-cycle (any phase, including HALTED): immediate return to INST_ADDR. In-flight wr/ld_ac are dropped asynchronously.
- No X propagation: an unknown opcode (X) decodes to no strobes except those that are phase-only.

Decomposition:
- Shared package `cpu_pkg` holds:
  - `opcode_t` enum (3-bit, values above); the ALU migrates to the same type.
  - `phase_t` enum (3-bit).
  - Helper function `is_aluop(opcode_t)`.
- No sub-module: the phase register plus the decode `always_comb` fit in one module.

Test Plan:
- Reset, then 8 posedges with opcode=ADD -> phase 0..7 then 0. At phase 7: rd=1, ld_ac=1, wr=0, data_e=0.
- opcode=STO -> phase 6: data_e=1, wr=0. Phase 7: data_e=1, wr=1, ld_ac=0, rd=0.
- opcode=SKZ, zero=1 -> inc_pc high in phase 4 and phase 6 (two increments per cycle). Repeat with zero=0 -> inc_pc only in phase 4.
- opcode=JMP -> ld_pc=1 in phases 6 and 7, inc_pc=1 in phase 4, no rd in phases 5-7.
- HALT_STICKY=1, opcode=HLT -> halt=1 in phase 4, then phase stays 4 with halt=1 for 20 cycles. Assert rst for 1 ns -> phase=0, halt=0, sel=1.
- Assert rst asynchronously mid-phase 7 of STO -> wr and data_e drop to 0 before the next posedge. phase=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode/phase types for the 8-bit accumulator CPU
package cpu_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_t;

   // An unknown opcode falls through to default, so X never produces a strobe.
   function automatic logic is_aluop(input opcode_t op);
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-phase sequencer driving the accumulator CPU datapath
module cpu_controller
   import cpu_pkg::*;
#(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase
);

   phase_t  phase_q, phase_d;
   logic    halted_q, halted_d;
   opcode_t op;
   logic    alu;

   assign op    = opcode_t'(opcode);
   assign phase = phase_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Decode uses if-tests on equality so an X opcode or zero reads as false.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      sel      = 1'b0;
      rd       = 1'b0;
      ld_ir    = 1'b0;
      inc_pc   = 1'b0;
      ld_pc    = 1'b0;
      ld_ac    = 1'b0;
      wr       = 1'b0;
      data_e   = 1'b0;
      halt     = 1'b0;
      alu      = is_aluop(op);
      if (halted_q) begin
         halt = 1'b1;
      end else begin
         phase_d = phase_t'(phase_q + 3'd1);
         case (phase_q)
            PH_INST_ADDR: sel = 1'b1;
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = 1'b1;
               if (op == OP_HLT) begin
                  halt = 1'b1;
                  if (HALT_STICKY) begin
                     halted_d = 1'b1;
                     phase_d  = PH_OP_ADDR;
                  end
               end
            end
            PH_OP_FETCH: rd = alu;
            PH_ALU_OP: begin
               rd = alu;
               if (op == OP_SKZ && zero == 1'b1) inc_pc = 1'b1;
               if (op == OP_JMP) ld_pc = 1'b1;
               if (op == OP_STO) data_e = 1'b1;
            end
            PH_STORE: begin
               rd    = alu;
               ld_ac = alu;
               if (op == OP_JMP) ld_pc = 1'b1;
               if (op == OP_STO) begin
                  wr     = 1'b1;
                  data_e = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed-vector bench for cpu_controller
module tb_cpu_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
   logic [2:0] phase;
   logic [8:0] outs;

   int checks = 0;
   int errors = 0;

   cpu_controller #(.HALT_STICKY(1'b1)) dut (
      .clk    (clk),
      .rst    (rst),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .ld_pc  (ld_pc),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt),
      .phase  (phase)
   );

   always #5 clk = ~clk;

   // {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}
   assign outs = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};

   localparam logic [8:0] F0 = 9'b100000000;
   localparam logic [8:0] F1 = 9'b110000000;
   localparam logic [8:0] F2 = 9'b111000000;
   localparam logic [8:0] F3 = 9'b111000000;
   localparam logic [8:0] INC = 9'b000100000;

   localparam logic [71:0] T_ADD = {F0, F1, F2, F3, INC, 9'b010000000, 9'b010000000, 9'b010001000};
   localparam logic [71:0] T_STO = {F0, F1, F2, F3, INC, 9'b000000000, 9'b000000010, 9'b000000110};
   localparam logic [71:0] T_SKZ1 = {F0, F1, F2, F3, INC, 9'b000000000, 9'b000100000, 9'b000000000};
   localparam logic [71:0] T_SKZ0 = {F0, F1, F2, F3, INC, 9'b000000000, 9'b000000000, 9'b000000000};
   localparam logic [71:0] T_JMP = {F0, F1, F2, F3, INC, 9'b000000000, 9'b000010000, 9'b000010000};
   localparam logic [71:0] T_HLT = {F0, F1, F2, F3, 9'b000100001, 9'b0, 9'b0, 9'b0};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Walks phases 0..last from phase 0, checking phase and every strobe.
   task automatic run_cycle(input string name, input logic [2:0] op, input logic z,
                            input logic [71:0] tbl, input int last, input bit stop);
      logic [8:0] exp;
      opcode = op;
      zero   = z;
      #1;
      for (int p = 0; p <= last; p++) begin
         exp = tbl[(7 - p) * 9 +: 9];
         check($sformatf("%s phase%0d", name, p), 32'(phase), 32'(p));
         check($sformatf("%s outs%0d", name, p), 32'(outs), 32'(exp));
         if (!(stop && p == last)) step();
      end
   endtask

   initial begin
      rst    = 1'b1;
      opcode = 3'd2;
      zero   = 1'b0;
      @(negedge clk);
      check("reset phase", 32'(phase), 32'd0);
      check("reset outs", 32'(outs), 32'(F0));
      rst = 1'b0;

      run_cycle("ADD", 3'd2, 1'b0, T_ADD, 7, 1'b0);
      run_cycle("STO", 3'd6, 1'b0, T_STO, 7, 1'b0);
      run_cycle("SKZ z1", 3'd1, 1'b1, T_SKZ1, 7, 1'b0);
      run_cycle("SKZ z0", 3'd1, 1'b0, T_SKZ0, 7, 1'b0);
      run_cycle("JMP", 3'd7, 1'b0, T_JMP, 7, 1'b0);

      run_cycle("HLT", 3'd0, 1'b0, T_HLT, 4, 1'b0);
      opcode = 3'd2;
      zero   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         check($sformatf("halted phase %0d", i), 32'(phase), 32'd4);
         check($sformatf("halted outs %0d", i), 32'(outs), 32'b000000001);
         step();
      end

      #1 rst = 1'b1;
      #1;
      check("halt reset phase", 32'(phase), 32'd0);
      check("halt reset outs", 32'(outs), 32'(F0));
      rst = 1'b0;
      @(negedge clk);
      check("post reset phase", 32'(phase), 32'd1);
      for (int i = 0; i < 7; i++) step();
      check("realign phase", 32'(phase), 32'd0);

      run_cycle("STO rst", 3'd6, 1'b0, T_STO, 7, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("mid rst wr", 32'(wr), 32'd0);
      check("mid rst data_e", 32'(data_e), 32'd0);
      check("mid rst phase", 32'(phase), 32'd0);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
